// File: rtl/irq_stim_gen.sv
// irq_stim_gen: per-channel programmable interrupt pulse/level generator.
// Define IRQ_STIM_JITTER_EN to add LFSR jitter to delay and gap intervals.
module irq_stim_gen #(
  parameter int NumIrq   = 4,
  parameter int CntW     = 32,
  parameter int DefDelay = 800,
  parameter int DefWidth = 10,
  parameter int JitterW  = 4,
  localparam int IdxW    = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumIrq-1:0] start_i,
  input  logic [NumIrq-1:0] stop_i,
  input  logic              cfg_we_i,
  input  logic [IdxW-1:0]   cfg_idx_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [CntW-1:0]   cfg_delay_i,
  input  logic [CntW-1:0]   cfg_width_i,
  input  logic [CntW-1:0]   cfg_period_i,
  input  logic [CntW-1:0]   cfg_count_i,
  input  logic [NumIrq-1:0] irq_ack_i,
  output logic [NumIrq-1:0] irq_o,
  output logic [NumIrq-1:0] busy_o,
  output logic [NumIrq-1:0] done_o,
  output logic              cfg_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_ASSERT, S_GAP, S_DONE
  } state_e;

  logic [NumIrq-1:0] w_sel;
  logic              w_idx_ok;
  logic              r_err;

  assign w_idx_ok  = int'(cfg_idx_i) < NumIrq;
  assign cfg_err_o = r_err;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NumIrq; i++)
      w_sel[i] = cfg_we_i && (cfg_idx_i == IdxW'(i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= cfg_we_i && (!w_idx_ok || |(w_sel & busy_o));
  end

  for (genvar c = 0; c < NumIrq; c++) begin : g_ch
    state_e          r_state, w_state;
    logic [1:0]      r_mode;
    logic [CntW-1:0] r_delay, r_width, r_period, r_count;
    logic [CntW-1:0] r_cnt, w_cnt, r_rem, w_rem;
    logic [CntW-1:0] w_wid, w_per, w_gap, w_jit;
    logic            w_idle, w_wr, w_go;
    logic            r_irq, r_busy, r_done;

    assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_wr   = w_sel[c] && w_idle;
    assign w_go   = start_i[c] && !stop_i[c] && w_idle;

    // Rising edges never closer than width+1: at least one low cycle.
    assign w_wid = (r_width == '0) ? CntW'(1) : r_width;
    assign w_per = (r_period > w_wid) ? r_period : w_wid + CntW'(1);
    assign w_gap = w_per - w_wid - CntW'(1);

`ifdef IRQ_STIM_JITTER_EN
    localparam logic [JitterW-1:0] LfsrTaps =
      JitterW'((JitterW == 4) ? 'hC : ((1 << (JitterW - 1)) | 1));
    logic [JitterW-1:0] r_lfsr;
    logic               w_step;

    assign w_step = w_go || (r_state == S_ASSERT && w_state == S_GAP);
    assign w_jit  = CntW'(r_lfsr);

    always_ff @(posedge clk_i) begin
      if (rst_i)       r_lfsr <= JitterW'(c + 1);
      else if (w_step) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LfsrTaps : '0);
    end
`else
    assign w_jit = '0;
`endif

    always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_rem   = r_rem;
      if (stop_i[c]) begin
        w_state = S_IDLE;
      end else begin
        unique case (r_state)
          S_DELAY: begin
            if (r_cnt == '0) begin
              w_state = S_ASSERT;
              w_cnt   = w_wid - CntW'(1);
            end else begin
              w_cnt = r_cnt - CntW'(1);
            end
          end
          S_ASSERT: begin
            if (r_mode == 2'd2) begin
              if (irq_ack_i[c]) w_state = S_DONE;
            end else if (r_cnt != '0) begin
              w_cnt = r_cnt - CntW'(1);
            end else if (r_mode != 2'd1 || r_rem == CntW'(1)) begin
              w_state = S_DONE;
            end else begin
              w_state = S_GAP;
              w_cnt   = w_gap + w_jit;
              if (r_rem != '0) w_rem = r_rem - CntW'(1);
            end
          end
          S_GAP: begin
            if (r_cnt == '0) begin
              w_state = S_ASSERT;
              w_cnt   = w_wid - CntW'(1);
            end else begin
              w_cnt = r_cnt - CntW'(1);
            end
          end
          default: begin
            if (start_i[c]) begin
              w_state = S_DELAY;
              w_cnt   = (w_wr ? cfg_delay_i : r_delay) + w_jit;
              w_rem   = w_wr ? cfg_count_i : r_count;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_rem   <= '0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_rem   <= w_rem;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_mode   <= 2'd0;
        r_delay  <= CntW'(DefDelay);
        r_width  <= CntW'(DefWidth);
        r_period <= '0;
        r_count  <= CntW'(1);
      end else if (w_wr) begin
        r_mode   <= cfg_mode_i;
        r_delay  <= cfg_delay_i;
        r_width  <= cfg_width_i;
        r_period <= cfg_period_i;
        r_count  <= cfg_count_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_irq  <= 1'b0;
        r_busy <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_irq  <= (w_state == S_ASSERT);
        r_busy <= (w_state == S_DELAY) || (w_state == S_ASSERT) ||
                  (w_state == S_GAP);
        r_done <= (w_state == S_DONE) || (r_done && !w_go);
      end
    end

    assign irq_o[c]  = r_irq;
    assign busy_o[c] = r_busy;
    assign done_o[c] = r_done;
  end

endmodule

// File: tb/tb_irq_stim_gen.sv
// Bench for irq_stim_gen: pulse-train timing model, directed
// and randomized channel scenarios.
module tb_irq_stim_gen;
  localparam int N  = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  start_i, stop_i, irq_ack_i;
  logic [N-1:0]  irq_o, busy_o, done_o;
  logic          start_a [N];
  logic          stop_a  [N];
  logic          ack_a   [N];
  logic          cfg_we;
  logic [1:0]    cfg_idx, cfg_mode;
  logic [CW-1:0] cfg_delay, cfg_width, cfg_period, cfg_count;
  logic          cfg_err;
  int            n_chk  = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      start_i[i]   = start_a[i];
      stop_i[i]    = stop_a[i];
      irq_ack_i[i] = ack_a[i];
    end
  end

  irq_stim_gen #(.NumIrq(N), .CntW(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .start_i(start_i), .stop_i(stop_i),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_mode_i(cfg_mode), .cfg_delay_i(cfg_delay),
    .cfg_width_i(cfg_width), .cfg_period_i(cfg_period),
    .cfg_count_i(cfg_count), .irq_ack_i(irq_ack_i),
    .irq_o(irq_o), .busy_o(busy_o), .done_o(done_o),
    .cfg_err_o(cfg_err)
  );

  // Expected {irq, busy, done} n cycles after the start edge.
  function automatic logic [2:0] model(input int mode, dly, wid, per,
                                       cnt, ack, n);
    int w, p, first, k, m, d;
    logic hi;
    w     = (wid == 0) ? 1 : wid;
    p     = (per > w) ? per : w + 1;
    first = dly + 1;
    k     = (mode == 1) ? cnt : 1;
    if (mode == 2) begin
      hi = (n >= first) && (n <= ack);
      d  = ack + 1;
    end else begin
      m  = n - first;
      hi = (n >= first) && (m % p < w) && (k == 0 || m / p < k);
      d  = (k == 0) ? 32'h7fffffff : first + (k - 1) * p + w;
    end
    return {hi, n < d, n >= d};
  endfunction

  function automatic int run_len(input int mode, dly, wid, per, cnt, ack);
    int w, p, k;
    w = (wid == 0) ? 1 : wid;
    p = (per > w) ? per : w + 1;
    k = (mode == 1) ? cnt : 1;
    if (mode == 2) return ack + 3;
    if (k == 0)    return dly + 1 + 3 * p + w;
    return dly + 1 + (k - 1) * p + w + 2;
  endfunction

  task automatic set_cfg(input int ch, mode, dly, wid, per, cnt);
    cfg_idx    = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_delay  = CW'(dly);
    cfg_width  = CW'(wid);
    cfg_period = CW'(per);
    cfg_count  = CW'(cnt);
  endtask

  task automatic write_cfg(input int ch, mode, dly, wid, per, cnt);
    @(negedge clk);
    set_cfg(ch, mode, dly, wid, per, cnt);
    cfg_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    n_chk++;
    if (cfg_err !== 1'b0)
      $display("FAIL cfg_write ch%0d: cfg_err=%b expected 0", ch, cfg_err);
    else n_pass++;
  endtask

  task automatic run_ch(input int ch, mode, dly, wid, per, cnt, ack,
                        input bit do_cfg, input string nm);
    int len, k;
    logic [2:0] got, exp;
    bit ok;
    len = run_len(mode, dly, wid, per, cnt, ack);
    k   = (mode == 1) ? cnt : 1;
    @(negedge clk);
    if (do_cfg) begin
      set_cfg(ch, mode, dly, wid, per, cnt);
      cfg_we = 1'b1;
    end
    start_a[ch] = 1'b1;
    @(posedge clk);
    ok = 1'b1;
    for (int n = 0; n < len && ok; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start_a[ch] = 1'b0;
        if (do_cfg) begin
          cfg_we = 1'b0;
          n_chk++;
          if (cfg_err !== 1'b0)
            $display("FAIL %s cfg_err: got %b expected 0", nm, cfg_err);
          else n_pass++;
        end
      end
      got = {irq_o[ch], busy_o[ch], done_o[ch]};
      exp = model(mode, dly, wid, per, cnt, ack, n);
      n_chk++;
      if (got !== exp) begin
        $display("FAIL %s ch%0d cyc%0d: irq/busy/done=%b expected %b",
                 nm, ch, n, got, exp);
        ok = 1'b0;
      end else n_pass++;
      if (mode == 2)
        ack_a[ch] = (n == ack) || (n <= dly && $urandom_range(0, 1) == 1);
      else
        ack_a[ch] = ($urandom_range(0, 1) == 1);
    end
    ack_a[ch] = 1'b0;
    if (mode != 2 && k == 0) begin
      @(negedge clk);
      stop_a[ch] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      stop_a[ch] = 1'b0;
      got = {irq_o[ch], busy_o[ch], done_o[ch]};
      n_chk++;
      if (got !== 3'b000)
        $display("FAIL %s stop_unbounded: got %b expected 000", nm, got);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++;
    if ({irq_o, busy_o, done_o, cfg_err} !== '0)
      $display("FAIL reset_hold: outs=%b expected 0",
               {irq_o, busy_o, done_o, cfg_err});
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({irq_o, busy_o, done_o, cfg_err} !== '0)
      $display("FAIL reset_release: outs=%b expected 0",
               {irq_o, busy_o, done_o, cfg_err});
    else n_pass++;
  endtask

  task automatic test_defaults;
    run_ch(0, 0, 800, 10, 0, 1, 0, 1'b0, "defaults");
  endtask

  task automatic test_periodic;
    run_ch(1, 1, 2, 3, 5, 3, 0, 1'b1, "periodic");
    run_ch(0, 1, 3, 4, 2, 2, 0, 1'b1, "min_gap");
    run_ch(1, 3, 1, 0, 0, 5, 0, 1'b1, "reserved_mode");
  endtask

  task automatic test_level;
    run_ch(2, 2, 0, 5, 0, 1, 20, 1'b1, "level_ack");
  endtask

  task automatic test_stop;
    logic [2:0] got;
    @(negedge clk);
    set_cfg(2, 0, 1, 20, 0, 1);
    cfg_we     = 1'b1;
    start_a[2] = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      if (n == 0) begin
        cfg_we     = 1'b0;
        start_a[2] = 1'b0;
      end
      if (n == 5) begin
        n_chk++;
        if (irq_o[2] !== 1'b1)
          $display("FAIL stop_pre: irq=%b expected 1", irq_o[2]);
        else n_pass++;
        stop_a[2]  = 1'b1;
        start_a[2] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    stop_a[2]  = 1'b0;
    start_a[2] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      got = {irq_o[2], busy_o[2], done_o[2]};
      n_chk++;
      if (got !== 3'b000)
        $display("FAIL stop_after%0d: irq/busy/done=%b expected 000", n, got);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_cfg_err;
    fork
      run_ch(1, 1, 6, 3, 5, 2, 0, 1'b1, "busy_write");
      begin
        repeat (4) @(negedge clk);
        set_cfg(1, 0, 0, 1, 2, 1);
        cfg_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b1)
          $display("FAIL err_busy: cfg_err=%b expected 1", cfg_err);
        else n_pass++;
        cfg_idx = 2'd3;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b1)
          $display("FAIL err_range: cfg_err=%b expected 1", cfg_err);
        else n_pass++;
        cfg_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b0)
          $display("FAIL err_pulse: cfg_err=%b expected 0", cfg_err);
        else n_pass++;
      end
    join
  endtask

  task automatic test_random;
    int ch, mode, dly, wid, per, cnt, ack;
    for (int it = 0; it < 10; it++) begin
      ch   = $urandom_range(0, N - 1);
      mode = $urandom_range(0, 3);
      dly  = $urandom_range(0, 12);
      wid  = $urandom_range(0, 5);
      per  = $urandom_range(0, 10);
      cnt  = $urandom_range(0, 4);
      ack  = dly + 1 + $urandom_range(0, 5);
      run_ch(ch, mode, dly, wid, per, cnt, ack, 1'b1, "random");
    end
  endtask

  task automatic test_back_to_back;
    write_cfg(0, 1, 3, 2, 4, 3);
    write_cfg(2, 0, 5, 7, 0, 1);
    fork
      run_ch(0, 1, 3, 2, 4, 3, 0, 1'b0, "parallel0");
      run_ch(2, 0, 5, 7, 0, 1, 0, 1'b0, "parallel2");
    join
    run_ch(0, 1, 3, 2, 4, 3, 0, 1'b0, "restart0");
  endtask

  initial begin
    rst    = 1'b1;
    cfg_we = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      start_a[i] = 1'b0;
      stop_a[i]  = 1'b0;
      ack_a[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    test_reset;
    test_defaults;
    test_periodic;
    test_level;
    test_stop;
    test_cfg_err;
    test_random;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
